hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Produces the stall_en and write-enable controls that drive the Decode/Execute
//  pipeline register, plus the PC and IF/ID write enables, for the 16-bit pipelined core.
//  Detects load-use hazards between the instruction in EX and the instruction in ID.
//  Freezes the pipeline while data memory is busy, with a timeout.
//  Handles branch flush of IF/ID and latches HLT.
// PARAMETERS
//  REG_W         4   register-specifier width
//  MAX_MEM_WAIT  8   max consecutive mem_busy cycles tolerated before timeout
//  CNT_W         16  width of stall counter (STALL_CNT_EN only)
// PORTS
//  clk            in   1      clock
//  rst_n          in   1      asynchronous active-low reset
//  idex_memread   in   1      instruction in EX is LW
//  idex_dstReg    in   REG_W  destination register of instruction in EX
//  ifid_srcReg1   in   REG_W  source 1 of instruction in ID
//  ifid_srcReg2   in   REG_W  source 2 of instruction in ID
//  ifid_uses_src2 in   1      ID instruction reads srcReg2
//  mem_busy       in   1      data memory not ready this cycle
//  branch_taken   in   1      ID resolved a taken branch
//  halt_dec       in   1      HLT decoded in ID
//  stall_en       out  1      bubble into ID/EX (clears it at next edge)
//  pc_wen         out  1      PC write enable
//  ifid_wen       out  1      IF/ID write enable
//  ifid_flush     out  1      clear IF/ID at next edge
//  pipe_freeze    out  1      hold every pipeline register (memory wait)
//  halted         out  1      core halted (sticky)
//  mem_timeout    out  1      mem_busy exceeded MAX_MEM_WAIT (sticky)
// BEHAVIOUR
//  Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
//  FSM states: RUN, MEM_WAIT, HALT. Reset -> RUN; wait_cnt=0; halted=0; mem_timeout=0.
//  Load-use detect (comb): lu = idex_memread & idex_dstReg!=0 &
//    (idex_dstReg==ifid_srcReg1 | (ifid_uses_src2 & idex_dstReg==ifid_srcReg2)).
//  Outputs in RUN (Mealy, same cycle), priority mem_busy > lu > branch_taken > halt_dec:
//   mem_busy:     pipe_freeze=1, pc_wen=0, ifid_wen=0, stall_en=0; next=MEM_WAIT, wait_cnt=1.
//   lu:           stall_en=1, pc_wen=0, ifid_wen=0, ifid_flush=0. Exactly one bubble per load;
//                 the next cycle sees the bubble in EX (memread=0), so lu clears.
//   branch_taken: ifid_flush=1, pc_wen=1, ifid_wen=1, stall_en=0.
//   halt_dec:     pc_wen=0, ifid_wen=0; next=HALT.
//   none:         pc_wen=1, ifid_wen=1; all other outputs 0.
//  MEM_WAIT: pipe_freeze=1, pc_wen=0, ifid_wen=0, stall_en=0 (ID/EX contents held, not cleared).
//   mem_busy=0 -> RUN, wait_cnt=0; lu/branch are re-evaluated in RUN on the next cycle.
//   mem_busy=1 & wait_cnt==MAX_MEM_WAIT -> mem_timeout=1, next=HALT.
//   else wait_cnt+1. wait_cnt saturates and never wraps.
//  HALT: halted=1, pc_wen=0, ifid_wen=0, stall_en=1 every cycle. Left only by reset.
//  Reset mid-MEM_WAIT or mid-HALT: all outputs return to reset values asynchronously.
//  Reset values: stall_en=0, pc_wen=1, ifid_wen=1, ifid_flush=0, pipe_freeze=0,
//   halted=0, mem_timeout=0.
// CONFIGURATION
//  STALL_CNT_EN defined:
//   - Adds output stall_cycles [CNT_W-1:0], reset 0.
//   - Counts +1 on each edge where stall_en|pipe_freeze is 1 and state!=HALT.
//   - Saturates at all-ones.
//  STALL_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  LW R3 in EX (dst=3), ID src1=3 -> stall_en=1, pc_wen=0 for exactly 1 cycle, then pc_wen=1.
//  dst=0, memread=1, src1=0 -> no stall. Src2 match with ifid_uses_src2=0 -> no stall.
//  mem_busy high 3 cycles -> pipe_freeze=1 for 3 cycles, RUN on cycle 4, mem_timeout=0.
//  mem_busy high 10 cycles (MAX_MEM_WAIT=8) -> mem_timeout=1, halted=1; only rst_n clears.
//  lu and branch_taken together -> stall_en=1, ifid_flush=0.
//   Next cycle branch_taken alone -> ifid_flush=1.
//  halt_dec, then rst_n low mid-HALT -> outputs at reset values immediately.
//   STALL_CNT_EN: 1 lu + 3 wait cycles -> stall_cycles=4.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Load-use / memory-wait / branch-flush / halt control for the 16-bit pipelined core.
// Optional STALL_CNT_EN adds a saturating stall_cycles counter output.
module hazard_stall_ctrl #(
  parameter int REG_W        = 4,
  parameter int MAX_MEM_WAIT = 8
`ifdef STALL_CNT_EN
  ,
  parameter int CNT_W        = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_dstReg,
  input  logic [REG_W-1:0] ifid_srcReg1,
  input  logic [REG_W-1:0] ifid_srcReg2,
  input  logic             ifid_uses_src2,
  input  logic             mem_busy,
  input  logic             branch_taken,
  input  logic             halt_dec,
  output logic             stall_en,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             ifid_flush,
  output logic             pipe_freeze,
  output logic             halted,
`ifdef STALL_CNT_EN
  output logic [CNT_W-1:0] stall_cycles,
`endif
  output logic             mem_timeout
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  localparam int WCNT_W = $clog2(MAX_MEM_WAIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MAX_MEM_WAIT);

  logic [1:0]        r_state;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic              r_mem_timeout;

  logic [1:0]        w_next;
  logic [WCNT_W-1:0] w_wait_nxt;
  logic              w_to_set;
  logic              w_lu;
  logic              w_stall;
  logic              w_pc_wen;
  logic              w_ifid_wen;
  logic              w_flush;
  logic              w_freeze;

  // A load into R0 never creates a dependency; src2 only matters if ID reads it.
  assign w_lu = idex_memread && (idex_dstReg != '0) &&
                ((idex_dstReg == ifid_srcReg1) ||
                 (ifid_uses_src2 && (idex_dstReg == ifid_srcReg2)));

  always_comb begin
    w_stall    = 1'b0;
    w_pc_wen   = 1'b1;
    w_ifid_wen = 1'b1;
    w_flush    = 1'b0;
    w_freeze   = 1'b0;
    w_next     = r_state;
    w_wait_nxt = r_wait_cnt;
    w_to_set   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (mem_busy) begin
          w_freeze   = 1'b1;
          w_pc_wen   = 1'b0;
          w_ifid_wen = 1'b0;
          w_next     = ST_MEM_WAIT;
          w_wait_nxt = WCNT_W'(1);
        end else if (w_lu) begin
          w_stall    = 1'b1;
          w_pc_wen   = 1'b0;
          w_ifid_wen = 1'b0;
        end else if (branch_taken) begin
          w_flush    = 1'b1;
        end else if (halt_dec) begin
          w_pc_wen   = 1'b0;
          w_ifid_wen = 1'b0;
          w_next     = ST_HALT;
        end
      end
      ST_MEM_WAIT: begin
        // The cycle memory answers releases the pipe; hazards are looked at again in RUN.
        if (mem_busy) begin
          w_freeze   = 1'b1;
          w_pc_wen   = 1'b0;
          w_ifid_wen = 1'b0;
          if (r_wait_cnt == WAIT_MAX) begin
            w_to_set = 1'b1;
            w_next   = ST_HALT;
          end else if (r_wait_cnt < WAIT_MAX) begin
            w_wait_nxt = r_wait_cnt + WCNT_W'(1);
          end
        end else begin
          w_next     = ST_RUN;
          w_wait_nxt = '0;
        end
      end
      ST_HALT: begin
        w_stall    = 1'b1;
        w_pc_wen   = 1'b0;
        w_ifid_wen = 1'b0;
      end
      default: begin
        w_next     = ST_RUN;
        w_wait_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_nxt;
      if (w_to_set) r_mem_timeout <= 1'b1;
    end
  end

  // Mealy outputs are forced to their reset values while rst_n is low.
  assign stall_en    = rst_n & w_stall;
  assign pc_wen      = ~rst_n | w_pc_wen;
  assign ifid_wen    = ~rst_n | w_ifid_wen;
  assign ifid_flush  = rst_n & w_flush;
  assign pipe_freeze = rst_n & w_freeze;
  assign halted      = (r_state == ST_HALT);
  assign mem_timeout = r_mem_timeout;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if ((w_stall || w_freeze) && (r_state != ST_HALT) && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus random stimulus against a behavioural model.
module tb_hazard_stall_ctrl;

  localparam int REG_W = 4;
  localparam int MAXW  = 8;
  localparam logic [6:0] RST_VEC = 7'b0110000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             memread;
  logic [REG_W-1:0] dst, s1, s2;
  logic             u2, busy, br, hlt;
  logic             stall_en, pc_wen, ifid_wen, ifid_flush, pipe_freeze, halted, mem_timeout;
`ifdef STALL_CNT_EN
  logic [15:0]      stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: 0 = running, 1 = waiting on memory, 2 = halted
  int          m_mode;
  int          m_wait;
  logic        m_to;
  int          m_scnt;
  logic [6:0]  exp_v;

  hazard_stall_ctrl #(.REG_W(REG_W), .MAX_MEM_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .idex_memread(memread), .idex_dstReg(dst),
    .ifid_srcReg1(s1), .ifid_srcReg2(s2), .ifid_uses_src2(u2),
    .mem_busy(busy), .branch_taken(br), .halt_dec(hlt),
    .stall_en(stall_en), .pc_wen(pc_wen), .ifid_wen(ifid_wen),
    .ifid_flush(ifid_flush), .pipe_freeze(pipe_freeze), .halted(halted),
`ifdef STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired: bench did not finish");
    $fatal(1);
  end

  function automatic logic [6:0] obs();
    return {stall_en, pc_wen, ifid_wen, ifid_flush, pipe_freeze, halted, mem_timeout};
  endfunction

  // {stall_en, pc_wen, ifid_wen, ifid_flush, pipe_freeze, halted, mem_timeout}
  function automatic logic [6:0] model_out();
    logic lu;
    lu = memread && (dst != 0) && ((dst == s1) || (u2 && (dst == s2)));
    if (!rst_n) return RST_VEC;
    if (m_mode == 2) return {6'b100001, m_to};
    if (m_mode == 1) return busy ? 7'b0000100 : 7'b0110000;
    if (busy) return 7'b0000100;
    if (lu)   return 7'b1000000;
    if (br)   return 7'b0111000;
    if (hlt)  return 7'b0000000;
    return 7'b0110000;
  endfunction

  task automatic model_step();
    logic [6:0] o;
    logic lu;
    o  = model_out();
    lu = memread && (dst != 0) && ((dst == s1) || (u2 && (dst == s2)));
    if (m_mode != 2 && (o[6] || o[2]) && m_scnt < 65535) m_scnt++;
    case (m_mode)
      0: if (busy) begin m_mode = 1; m_wait = 1; end
         else if (!lu && !br && hlt) m_mode = 2;
      1: if (!busy) begin m_mode = 0; m_wait = 0; end
         else if (m_wait == MAXW) begin m_to = 1'b1; m_mode = 2; end
         else m_wait++;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_mode = 0; m_wait = 0; m_to = 1'b0; m_scnt = 0;
  endtask

  task automatic set_in(input logic mr, input int d, input int a, input int b,
                        input logic us2, input logic mb, input logic bt, input logic hd);
    memread = mr; dst = REG_W'(d); s1 = REG_W'(a); s2 = REG_W'(b);
    u2 = us2; busy = mb; br = bt; hlt = hd;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1, 3, 3, 0, 0, 1, 1, 1);
    model_reset();
    #2;
    checks++;
    if (obs() !== RST_VEC) begin
      errors++; $display("FAIL reset_vals got=%b exp=%b", obs(), RST_VEC);
    end
    do_reset();
  endtask

  task automatic test_load_use();
    // LW R3 in EX vs ID src1=3, then the bubble; R0 load; src2 match with src2 unused
    int tbl[5][5] = '{'{1,3,3,0,0}, '{0,0,3,0,0}, '{1,0,0,0,1}, '{1,5,1,5,0}, '{1,5,1,5,1}};
    for (int i = 0; i < 5; i++) begin
      set_in(tbl[i][0] != 0, tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4] != 0, 0, 0, 0);
      @(negedge clk);
      exp_v = model_out();
      checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL load_use row=%0d got=%b exp=%b", i, obs(), exp_v);
      end
      @(posedge clk); model_step(); #1;
    end
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 6; i++) begin
      set_in(0, 0, 0, 0, 0, i < 3, 0, 0);
      @(negedge clk);
      exp_v = model_out();
      checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL mem_wait cyc=%0d got=%b exp=%b", i, obs(), exp_v);
      end
      @(posedge clk); model_step(); #1;
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 14; i++) begin
      set_in(0, 0, 0, 0, 0, i < 10, 0, 0);
      @(negedge clk);
      exp_v = model_out();
      checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL timeout cyc=%0d got=%b exp=%b", i, obs(), exp_v);
      end
      @(posedge clk); model_step(); #1;
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (obs() !== RST_VEC) begin
      errors++; $display("FAIL timeout_clear got=%b exp=%b", obs(), RST_VEC);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lu_branch();
    // load-use and branch together, then branch alone, then nothing
    for (int i = 0; i < 3; i++) begin
      if (i == 0)      set_in(1, 2, 2, 0, 0, 0, 1, 0);
      else if (i == 1) set_in(0, 0, 2, 0, 0, 0, 1, 0);
      else             set_in(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      exp_v = model_out();
      checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL lu_branch cyc=%0d got=%b exp=%b", i, obs(), exp_v);
      end
      @(posedge clk); model_step(); #1;
    end
  endtask

  task automatic test_halt_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, i == 0);
      @(negedge clk);
      exp_v = model_out();
      checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL halt cyc=%0d got=%b exp=%b", i, obs(), exp_v);
      end
      @(posedge clk); model_step(); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== RST_VEC) begin
      errors++; $display("FAIL halt_async_reset got=%b exp=%b", obs(), RST_VEC);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

`ifdef STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) set_in(1, 4, 4, 0, 0, 0, 0, 0);
      else        set_in(0, 0, 0, 0, 0, i < 4, 0, 0);
      @(posedge clk); model_step(); #1;
    end
    checks++;
    if (stall_cycles !== 16'd4) begin
      errors++; $display("FAIL stall_cycles got=%0d exp=4", stall_cycles);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (m_mode == 2 && $urandom_range(0, 3) == 0) do_reset();
      set_in($urandom_range(0, 1) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 1) != 0, $urandom_range(0, 9) < 2,
             $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0);
      if (m_mode == 1 && $urandom_range(0, 1) == 0) busy = 1'b1;
      @(negedge clk);
      exp_v = model_out();
      checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL random cyc=%0d got=%b exp=%b", i, obs(), exp_v);
      end
`ifdef STALL_CNT_EN
      checks++;
      if (stall_cycles !== 16'(m_scnt)) begin
        errors++; $display("FAIL random_cnt cyc=%0d got=%0d exp=%0d", i, stall_cycles, m_scnt);
      end
`endif
      @(posedge clk); model_step(); #1;
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_lu_branch();
    test_halt_reset();
`ifdef STALL_CNT_EN
    test_stall_cnt();
`endif
    do_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
